// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl_if
//  Description : Bundles the CPU request/response, cache-array control and
//                backing-RAM handshake signals of the cache controller.
//                slave  = controller view, master = environment view.
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int WAYS      = 4,
    parameter int RAM_DEPTH = 256
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int WW = $clog2(WAYS);

    // CPU side
    logic             req_valid;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             req_ready;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;

    // Cache arrays
    logic [AW-1:0]    cache_addr;
    logic             cache_re;
    logic             cache_we;
    logic [WW-1:0]    cache_way;
    logic [WIDTH-1:0] cache_wdata;
    logic             cache_hit;
    logic [WW-1:0]    cache_hit_way;
    logic [WIDTH-1:0] cache_rdata;
    logic [WW-1:0]    replace_way;

    // Backing RAM
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  cache_hit, cache_hit_way, cache_rdata, replace_way,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output cache_addr, cache_re, cache_we, cache_way, cache_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output cache_hit, cache_hit_way, cache_rdata, replace_way,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  cache_addr, cache_re, cache_we, cache_way, cache_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ctrl
//  Description : Sequencing FSM for a set-associative, write-through,
//                read-allocate cache. One request at a time: tag lookup,
//                RAM refill on read miss, RAM write for every store.
//                Optional macro CACHE_CTRL_STATS_EN adds saturating
//                hit/miss counters.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_ctrl #(
    parameter int WIDTH      = 8,
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    parameter int RAM_DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    cache_ctrl_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    localparam int AW = $clog2(RAM_DEPTH);

    // Reject geometries the index/tag split downstream cannot represent
    if (((TOTAL_SIZE % WAYS) != 0) || ((1 << $clog2(WAYS)) != WAYS)) begin : g_cfg_check
        $error("cache_ctrl: WAYS must be a power of two dividing TOTAL_SIZE");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_data;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch and read-data capture (from hit lookup or RAM refill)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == S_IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == S_LOOKUP && !r_we && bus.cache_hit) begin
                r_data <= bus.cache_rdata;
            end
            if (r_state == S_MEM_RD && bus.mem_ack) begin
                r_data <= bus.mem_rdata;
            end
        end
    end

    // Next-state and output decode; every output is idle-low by default
    always_comb begin
        w_next_state     = r_state;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rdata   = '0;
        bus.cache_addr   = '0;
        bus.cache_re     = 1'b0;
        bus.cache_we     = 1'b0;
        bus.cache_way    = '0;
        bus.cache_wdata  = '0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;

        unique case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                bus.cache_addr = r_addr;
                if (bus.cache_hit) begin
                    if (r_we) begin
                        // Update the resident copy, then write through
                        bus.cache_we    = 1'b1;
                        bus.cache_way   = bus.cache_hit_way;
                        bus.cache_wdata = r_wdata;
                        w_next_state    = S_MEM_WR;
                    end else begin
                        // Read strobe also refreshes LRU for this way
                        bus.cache_re = 1'b1;
                        w_next_state = S_RESP;
                    end
                end else begin
                    // Write miss: no allocate, RAM write only
                    w_next_state = r_we ? S_MEM_WR : S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                bus.cache_addr = r_addr;
                bus.mem_req    = 1'b1;
                bus.mem_addr   = r_addr;
                if (bus.mem_ack) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                bus.cache_addr  = r_addr;
                bus.cache_we    = 1'b1;
                bus.cache_way   = bus.replace_way;
                bus.cache_wdata = r_data;
                w_next_state    = S_RESP;
            end
            S_MEM_WR: begin
                bus.cache_addr = r_addr;
                bus.mem_req    = 1'b1;
                bus.mem_we     = 1'b1;
                bus.mem_addr   = r_addr;
                bus.mem_wdata  = r_wdata;
                if (bus.mem_ack) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                bus.cache_addr = r_addr;
                bus.resp_valid = 1'b1;
                bus.resp_rdata = r_we ? '0 : r_data;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters, one step per lookup outcome
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count  <= 16'd0;
            r_miss_count <= 16'd0;
        end else if (r_state == S_LOOKUP) begin
            if (bus.cache_hit) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else begin
                if (r_miss_count != 16'hFFFF) begin
                    r_miss_count <= r_miss_count + 16'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_ctrl
//  Description : Self-checking bench for cache_ctrl: table of directed
//                transactions plus a hand-written reset-during-refill case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_ctrl;
    localparam int WIDTH      = 8;
    localparam int WAYS       = 4;
    localparam int TOTAL_SIZE = 16;
    localparam int RAM_DEPTH  = 256;
    localparam int NVEC       = 7;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cache_ctrl_if #(.WIDTH(WIDTH), .WAYS(WAYS), .RAM_DEPTH(RAM_DEPTH)) bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_ctrl #(
        .WIDTH(WIDTH), .WAYS(WAYS), .TOTAL_SIZE(TOTAL_SIZE), .RAM_DEPTH(RAM_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       hit;
        logic [1:0] hit_way;
        logic [7:0] crdata;
        logic [1:0] repl;
        int         ack_delay;   // cycles of mem_req before mem_ack
        logic [7:0] mrdata;
        int         exp_resp_cyc; // relative to acceptance cycle 0
        logic [7:0] exp_rdata;
        int         exp_re;
        int         exp_we;
        logic [1:0] exp_way;
        logic [7:0] exp_wdata;
        int         exp_mem_cyc;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         cyc;
        int         mem_cnt;
        int         re_cnt;
        int         we_cnt;
        int         resp_cyc;
        logic [1:0] way_seen;
        logic [7:0] wd_seen;
        logic [7:0] rd_seen;
        bit         done;
        cyc = 0; mem_cnt = 0; re_cnt = 0; we_cnt = 0; resp_cyc = -1;
        way_seen = '0; wd_seen = '0; rd_seen = '0; done = 0;

        @(posedge clk); #1;
        check($sformatf("v%0d_ready", idx), {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid     = 1'b1;
        bus.req_we        = v.we;
        bus.req_addr      = v.addr;
        bus.req_wdata     = v.wdata;
        bus.cache_hit     = v.hit;
        bus.cache_hit_way = v.hit_way;
        bus.cache_rdata   = v.crdata;
        bus.replace_way   = v.repl;
        bus.mem_rdata     = v.mrdata;
        bus.mem_ack       = 1'b0;

        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            // Scramble request inputs so only the latched copy can be used
            bus.req_valid = 1'b0;
            bus.req_we    = ~v.we;
            bus.req_addr  = ~v.addr;
            bus.req_wdata = ~v.wdata;
            bus.mem_ack   = 1'b0;
            if (bus.mem_req) begin
                bus.mem_ack = (mem_cnt == v.ack_delay);
                mem_cnt++;
            end
            #4;
            check($sformatf("v%0d_re_we_excl", idx), {31'd0, bus.cache_re & bus.cache_we}, 32'd0);
            if (bus.mem_req) begin
                check($sformatf("v%0d_mem_addr", idx), {24'd0, bus.mem_addr}, {24'd0, v.addr});
                check($sformatf("v%0d_mem_we", idx), {31'd0, bus.mem_we}, {31'd0, v.we});
                if (v.we) begin
                    check($sformatf("v%0d_mem_wdata", idx), {24'd0, bus.mem_wdata}, {24'd0, v.wdata});
                end
            end
            if (bus.cache_re) begin
                re_cnt++;
                check($sformatf("v%0d_re_addr", idx), {24'd0, bus.cache_addr}, {24'd0, v.addr});
            end
            if (bus.cache_we) begin
                we_cnt++;
                way_seen = bus.cache_way;
                wd_seen  = bus.cache_wdata;
                check($sformatf("v%0d_we_addr", idx), {24'd0, bus.cache_addr}, {24'd0, v.addr});
            end
            if (bus.resp_valid) begin
                resp_cyc = cyc;
                rd_seen  = bus.resp_rdata;
                done     = 1;
            end
        end

        check($sformatf("v%0d_resp_cycle", idx), resp_cyc, v.exp_resp_cyc);
        check($sformatf("v%0d_rdata", idx), {24'd0, rd_seen}, {24'd0, v.exp_rdata});
        check($sformatf("v%0d_re_pulses", idx), re_cnt, v.exp_re);
        check($sformatf("v%0d_we_pulses", idx), we_cnt, v.exp_we);
        check($sformatf("v%0d_mem_cycles", idx), mem_cnt, v.exp_mem_cyc);
        if (v.exp_we != 0) begin
            check($sformatf("v%0d_we_way", idx), {30'd0, way_seen}, {30'd0, v.exp_way});
            check($sformatf("v%0d_we_data", idx), {24'd0, wd_seen}, {24'd0, v.exp_wdata});
        end

        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        #4;
        check($sformatf("v%0d_resp_one_cycle", idx), {31'd0, bus.resp_valid}, 32'd0);
        check($sformatf("v%0d_back_idle", idx), {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // fields: we addr wdata hit hit_way crdata repl ack_delay mrdata
        //         exp_resp_cyc exp_rdata exp_re exp_we exp_way exp_wdata exp_mem_cyc
        vecs[0] = '{1'b0, 8'h05, 8'h00, 1'b0, 2'd0, 8'h00, 2'd1, 3, 8'h3C,  7, 8'h3C, 0, 1, 2'd1, 8'h3C, 4};
        vecs[1] = '{1'b0, 8'h05, 8'h00, 1'b1, 2'd2, 8'h3C, 2'd0, 0, 8'h99,  2, 8'h3C, 1, 0, 2'd0, 8'h00, 0};
        vecs[2] = '{1'b1, 8'h05, 8'hA7, 1'b1, 2'd2, 8'h3C, 2'd0, 1, 8'hEE,  4, 8'h00, 0, 1, 2'd2, 8'hA7, 2};
        vecs[3] = '{1'b1, 8'h80, 8'h11, 1'b0, 2'd0, 8'h00, 2'd1, 0, 8'h77,  3, 8'h00, 0, 0, 2'd0, 8'h00, 1};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 1'b0, 2'd0, 8'h00, 2'd3, 0, 8'h5A,  4, 8'h5A, 0, 1, 2'd3, 8'h5A, 1};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 2'd0, 8'hFF, 2'd2, 0, 8'h00,  2, 8'hFF, 1, 0, 2'd0, 8'h00, 0};
        vecs[6] = '{1'b1, 8'hFF, 8'h00, 1'b1, 2'd3, 8'h42, 2'd1, 2, 8'h00,  5, 8'h00, 0, 1, 2'd3, 8'h00, 3};

        rst               = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.cache_hit     = 1'b0;
        bus.cache_hit_way = '0;
        bus.cache_rdata   = '0;
        bus.replace_way   = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;

        #1;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_strobes", {30'd0, bus.cache_re, bus.cache_we}, 32'd0);
        check("rst_addrs", {16'd0, bus.cache_addr, bus.mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

`ifdef CACHE_CTRL_STATS_EN
        check("stats_hits", {16'd0, hit_count}, 32'd4);
        check("stats_misses", {16'd0, miss_count}, 32'd3);
`endif

        // Reset while a refill is outstanding, then a stale ack
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h10;
        bus.cache_hit = 1'b0;
        bus.mem_ack   = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid_mem_req_before", {31'd0, bus.mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
        check("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd1);
`ifdef CACHE_CTRL_STATS_EN
        check("rstmid_stats_clear", {hit_count, miss_count}, 32'd0);
`endif
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b1;
        #4;
        check("stale_ack_idle", {31'd0, bus.req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            #4;
            check($sformatf("stale_ack_quiet%0d", k),
                  {28'd0, bus.cache_we, bus.resp_valid, bus.mem_req, ~bus.req_ready}, 32'd0);
        end

        // Controller recovers and serves a normal hit
        run_vec(NVEC, vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
